rr_hold_arbiter: RTL and testbench

- Sequential round-robin arbiter that shares one resource between NumRequests requesters.
- Holds the grant for a whole transaction until the owner releases, drops its request, or times out.
- Sits between requesting engines and the shared datapath mux.
- Drives a one-hot grant and a binary select for that mux; select replaces the combinational fixed-priority selection.

---
 rtl/rr_hold_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_hold_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_hold_arbiter
// Brief    : Round-robin arbiter that holds a grant for a whole transaction.
// Revision : 1.0
// ============================================================================
module rr_hold_arbiter #(
    parameter int NUM_REQUESTS = 4,
    parameter int MAX_HOLD     = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQUESTS-1:0]         i_request,
    input  logic [NUM_REQUESTS-1:0]         i_release,
    output logic [NUM_REQUESTS-1:0]         o_grant,
    output logic [$clog2(NUM_REQUESTS)-1:0] o_select,
    output logic                            o_grant_valid,
    output logic                            o_timeout,
    output logic [$clog2(MAX_HOLD)-1:0]     o_hold_cnt
);

    localparam int c_SEL_W  = $clog2(NUM_REQUESTS);
    localparam int c_HOLD_W = $clog2(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
    localparam logic [c_SEL_W-1:0]  c_LAST_REQ  = c_SEL_W'(NUM_REQUESTS - 1);
    localparam logic [c_SEL_W:0]    c_NUM_REQ   = (c_SEL_W + 1)'(NUM_REQUESTS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                    r_state;
    logic [c_SEL_W-1:0]        r_ptr;
    logic [NUM_REQUESTS-1:0]   r_grant;
    logic [c_SEL_W-1:0]        r_select;
    logic                      r_grant_valid;
    logic                      r_timeout;
    logic [c_HOLD_W-1:0]       r_hold_cnt;

    logic [NUM_REQUESTS-1:0]   w_rot;
    logic                      w_found;
    logic [c_SEL_W:0]          w_sum;
    logic [c_SEL_W-1:0]        w_winner;
    logic                      w_own_rel;
    logic                      w_own_req;
    logic                      w_at_limit;
    logic                      w_terminate;
    logic                      w_expire;
    logic [c_SEL_W-1:0]        w_ptr_next;

    // Rotate requests so bit 0 is the pointer position; the first set bit
    // after rotation is the winner's distance from the pointer.
    always_comb begin
        w_rot    = NUM_REQUESTS'({i_request, i_request} >> r_ptr);
        w_found  = 1'b0;
        w_sum    = '0;
        w_winner = '0;
        for (int k = NUM_REQUESTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (c_SEL_W + 1)'(k);
            end
        end
        if (w_sum >= c_NUM_REQ) begin
            w_sum = w_sum - c_NUM_REQ;
        end
        w_winner = w_sum[c_SEL_W-1:0];
    end

    assign w_own_rel   = i_release[r_select];
    assign w_own_req   = i_request[r_select];
    assign w_at_limit  = (r_hold_cnt == c_HOLD_LAST);
    assign w_terminate = w_own_rel || !w_own_req || w_at_limit;
    // A release on the final allowed cycle is an orderly end, not a timeout.
    assign w_expire    = w_at_limit && w_own_req && !w_own_rel;
    assign w_ptr_next  = (r_select == c_LAST_REQ) ? '0 : r_select + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_select      <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant       <= NUM_REQUESTS'(1) << w_winner;
                        r_select      <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= '0;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_terminate) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                        r_ptr         <= w_ptr_next;
                        r_timeout     <= w_expire;
                        r_state       <= S_IDLE;
                    end else begin
                        r_hold_cnt    <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_select      = r_select;
    assign o_grant_valid = r_grant_valid;
    assign o_timeout     = r_timeout;
    assign o_hold_cnt    = r_hold_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_hold_arbiter
// Brief    : Directed vector bench for rr_hold_arbiter (4 requesters, hold 16).
// Revision : 1.0
// ============================================================================
module tb_rr_hold_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] request;
    logic [3:0] rel;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       grant_valid;
    logic       timeout;
    logic [3:0] hold_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] rel;
        logic [3:0] grant;
        logic       valid;
        logic [1:0] sel;
        logic       to;
        logic [3:0] hc;
    } vec_t;

    vec_t vq[$];

    rr_hold_arbiter #(
        .NUM_REQUESTS (4),
        .MAX_HOLD     (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_request     (request),
        .i_release     (rel),
        .o_grant       (grant),
        .o_select      (sel),
        .o_grant_valid (grant_valid),
        .o_timeout     (timeout),
        .o_hold_cnt    (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rn, input logic [3:0] rq, input logic [3:0] rl,
                       input logic [3:0] g, input logic v, input logic [1:0] s,
                       input logic t, input logic [3:0] h);
        vec_t e;
        e.rst_n = rn; e.req = rq; e.rel = rl;
        e.grant = g;  e.valid = v; e.sel = s; e.to = t; e.hc = h;
        vq.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s %s: got %0h expected %0h", tag, field, act, exp);
        else
            n_pass++;
    endtask

    task automatic check(input string tag, input logic [3:0] g, input logic v,
                         input logic [1:0] s, input logic t, input logic [3:0] h);
        cmp(tag, "grant",       32'(grant),           32'(g));
        cmp(tag, "grant_valid", 32'(grant_valid),     32'(v));
        cmp(tag, "select",      32'(sel),             32'(s));
        cmp(tag, "timeout",     32'(timeout),         32'(t));
        cmp(tag, "hold_cnt",    32'(hold_cnt),        32'(h));
        cmp(tag, "onehot0",     32'($onehot0(grant)), 32'd1);
    endtask

    task automatic step(input logic rn, input logic [3:0] rq, input logic [3:0] rl);
        rst_n   = rn;
        request = rq;
        rel     = rl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] oh;
        logic [3:0] oh_next;
        rst_n   = 1'b0;
        request = 4'b0000;
        rel     = 4'b0000;

        // Reset with all requesting, then first grant one edge after release.
        add(0, 4'b1111, 4'b0000, 4'b0000, 0, 2'd0, 0, 4'd0);
        add(0, 4'b1111, 4'b0000, 4'b0000, 0, 2'd0, 0, 4'd0);
        add(1, 4'b1111, 4'b0000, 4'b0001, 1, 2'd0, 0, 4'd0);

        // Round robin: foreign releases ignored, owner releases at hold_cnt=3.
        for (int o = 0; o < 4; o++) begin
            oh      = 4'b0001 << o;
            oh_next = 4'b0001 << ((o + 1) % 4);
            add(1, 4'b1111, ~oh,     oh,      1, 2'(o),         0, 4'd1);
            add(1, 4'b1111, 4'b0000, oh,      1, 2'(o),         0, 4'd2);
            add(1, 4'b1111, 4'b0000, oh,      1, 2'(o),         0, 4'd3);
            add(1, 4'b1111, oh,      4'b0000, 0, 2'(o),         0, 4'd0);
            add(1, 4'b1111, 4'b0000, oh_next, 1, 2'((o + 1) % 4), 0, 4'd0);
        end

        // Pointer skip: ptr=2 with only 0 and 1 requesting picks 0, then 1.
        add(1, 4'b1111, 4'b0001, 4'b0000, 0, 2'd0, 0, 4'd0);
        add(1, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1, 0, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1, 0, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1, 0, 4'd0);
        add(1, 4'b0011, 4'b0000, 4'b0001, 1, 2'd0, 0, 4'd0);
        add(1, 4'b0010, 4'b0000, 4'b0000, 0, 2'd0, 0, 4'd0);
        add(1, 4'b0011, 4'b0000, 4'b0010, 1, 2'd1, 0, 4'd0);

        // Owner 2 drops its request; release[1] and release[3] are ignored.
        add(1, 4'b0100, 4'b0010, 4'b0000, 0, 2'd1, 0, 4'd0);
        add(1, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 0, 4'd0);
        add(1, 4'b0100, 4'b0010, 4'b0100, 1, 2'd2, 0, 4'd1);
        add(1, 4'b0110, 4'b0000, 4'b0100, 1, 2'd2, 0, 4'd2);
        add(1, 4'b0100, 4'b1000, 4'b0100, 1, 2'd2, 0, 4'd3);
        add(1, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 0, 4'd4);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0, 4'd0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst_n, vq[i].req, vq[i].rel);
            check($sformatf("vec%0d", i), vq[i].grant, vq[i].valid, vq[i].sel,
                  vq[i].to, vq[i].hc);
        end

        // Timeout: requester 3 holds 16 cycles, then a one-cycle revoke pulse.
        step(1, 4'b1000, 4'b0000);
        check("to_grant", 4'b1000, 1, 2'd3, 0, 4'd0);
        for (int k = 1; k < 16; k++) begin
            step(1, 4'b1000, 4'b0000);
            check($sformatf("to_hold%0d", k), 4'b1000, 1, 2'd3, 0, 4'(k));
        end
        step(1, 4'b1000, 4'b0000);
        check("to_revoke", 4'b0000, 0, 2'd3, 1, 4'd0);
        // Pointer wrapped to 0, so 0 beats 3; timeout pulse has cleared.
        step(1, 4'b1001, 4'b0000);
        check("to_after", 4'b0001, 1, 2'd0, 0, 4'd0);

        // Release on the final allowed cycle is not a timeout.
        for (int k = 1; k < 16; k++) begin
            step(1, 4'b1001, 4'b0000);
            check($sformatf("lim_hold%0d", k), 4'b0001, 1, 2'd0, 0, 4'(k));
        end
        step(1, 4'b1001, 4'b0001);
        check("rel_at_limit", 4'b0000, 0, 2'd0, 0, 4'd0);

        // Reset mid-grant drops the grant and returns the pointer to 0.
        step(1, 4'b0010, 4'b0000);
        check("mr_grant", 4'b0010, 1, 2'd1, 0, 4'd0);
        for (int k = 1; k < 8; k++) begin
            step(1, 4'b0010, 4'b0000);
            check($sformatf("mr_hold%0d", k), 4'b0010, 1, 2'd1, 0, 4'(k));
        end
        step(0, 4'b0010, 4'b0000);
        check("mr_reset", 4'b0000, 0, 2'd0, 0, 4'd0);
        step(1, 4'b0011, 4'b0000);
        check("mr_after", 4'b0001, 1, 2'd0, 0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
